ld_seq: RTL
===========

# ld_seq

Load sequencer for MIX opcodes 8–23 (LDA, LD1–LD6, LDX and their negated forms). On `start`, it validates the opcode and field, fetches the operand word over a request/acknowledge memory port, extracts the field, and applies the optional sign inversion. It then issues one register-file write pulse. It sits between instruction decode and the register file, and is the only path by which loads reach A, I1–I6 and X.

## Interface
- `TIMEOUT`, default 255: cycles to wait for `mem_ack` before aborting (1–1023).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `opcode`  in  6  MIX opcode; legal range 8–23.
- `field`  in  6  F = 8L+R; L = `field[5:3]`, R = `field[2:0]`.
- `addr`  in  12  effective memory address M.
- `mem_req`  out  1  read request, held until acknowledged or timed out.
- `mem_addr`  out  12  address; stable while `mem_req` = 1.
- `mem_ack`  in  1  one-cycle acknowledge; `mem_data` is valid in the same cycle.
- `mem_data`  in  31  word: `[30]` sign, byte1 = `[29:24]` … byte5 = `[5:0]`.
- `wr_en`  out  1  one-cycle register write strobe.
- `wr_sel`  out  3  0 = A, 1–6 = I1–I6, 7 = X.
- `wr_data`  out  31  value to write.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; completion, success or error.
- `err`  out  1  one-cycle pulse, coincident with `done`, on illegal opcode/field or timeout.

## Operation
- **States:** IDLE, REQ, WB, ERR.
- **IDLE:**
  - On `start`, latch `opcode`, `field` and `addr`.
  - Illegal opcode (<8 or >23), L>R, or R>5 → ERR, without ever asserting `mem_req`.
  - Otherwise → REQ.
- **REQ:**
  - `mem_req` = 1, `mem_addr` = latched address, timeout counter increments.
  - `mem_ack` → capture `mem_data` and go to WB.
  - Counter reaching `TIMEOUT` without `mem_ack` → ERR.
  - `mem_ack` in the same cycle as the timeout → the ack wins.
- **WB:**
  - `wr_en` = 1, `done` = 1, `wr_sel` = `opcode[2:0]`.
  - → IDLE.
- **ERR:**
  - `err` = 1, `done` = 1, `wr_en` = 0.
  - → IDLE.
- **Field extraction:**
  - Bytes max(L,1)..R are right-justified into `[29:0]`; upper bits are zero.
  - Sign = `mem_data[30]` if L = 0, else + (0).
  - (0:0) yields a sign only, with magnitude 0.
- **Negation:** if `opcode[4]` = 1 (opcodes 16–23), invert the sign bit after extraction. −0 is legal and is written as-is.
- **Index targets (`wr_sel` 1–6):** `wr_data` = {sign, 18'd0, value[11:0]}. Magnitude bits 29:12 are silently discarded.
- **`start` while busy:** ignored and not queued.
- **Outputs outside their strobe cycle:** `wr_data` and `wr_sel` hold their last value; only `wr_en` qualifies them.

## Timing
- **Reset values:** state IDLE; `mem_req`, `wr_en`, `busy`, `done` and `err` all 0; `mem_addr`, `wr_sel` and `wr_data` 0; timeout counter 0.
- **Reset is asynchronous** and may occur in any state. It drops `mem_req` immediately, and no write or `done` follows. A late `mem_ack` arriving after reset is ignored.
- **Legal load:**
  - `start` at cycle 0 → `mem_req` high from cycle 1.
  - Ack at cycle k ≥ 1 → `wr_en`/`done` at cycle k+1 → IDLE at k+2.
  - Minimum latency is 2 cycles from `start` to `wr_en`.
- **Illegal load:** `start` at cycle 0 → `err`/`done` at cycle 1.
- **Timeout:** `err` is asserted exactly `TIMEOUT` + 1 cycles after `mem_req` rises.
- **Back-to-back:** a new `start` is accepted in the cycle the block returns to IDLE.

## Structure
- **Shared package `mix_pkg`:**
  - `WORD_W` = 31, `BYTE_W` = 6, `ADDR_W` = 12.
  - `OP_LD_FIRST` = 8, `OP_LD_LAST` = 23.
  - Register indices `REG_A`, `REG_I1`…`REG_I6`, `REG_X`.
  - State enum for ld_seq.
- **Sub-module `field_sel`:**
  - Purely combinational; inputs word and F, outputs extracted word and `valid` (L≤R, R≤5).
  - Reused later by compare and store sequencers.
- **`ld_seq` itself:** holds the FSM, the latches, the timeout counter, the negate/index-truncate stage and the output registers.

## Test plan
Word W = {1, 01, 02, 03, 04, 05} (sign −, bytes octal-free decimal).

- **Full-word load:** LDA (opcode 8), F = 5, addr 100, ack after 3 cycles → `mem_addr` = 100, `wr_sel` = 0, `wr_data` = W, `wr_en` at cycle 5.
- **Sign-dropping field:** LDA, F = 13 (1:5) → `wr_data` = {0, 01, 02, 03, 04, 05}. LDX (15), F = 36 (4:4) → `wr_sel` = 7, `wr_data` = 4.
- **Negated index load:** LD2N (18), F = 2 (0:2) → `wr_sel` = 2, `wr_data` = {0, 18'd0, 12'd66}. LDAN (16), F = 0 → `wr_data` = {0, 30'd0}.
- **Illegal requests:**
  - F = 26 (3:2) → `err` + `done` at cycle 1, `mem_req` never high.
  - opcode 7 → same response.
  - F = 6 (0:6) → same response.
- **Timeout and overlap:**
  - `TIMEOUT` = 4, no ack → `err` at the 5th cycle of `mem_req`.
  - A second `start` while busy → ignored.
- **Reset mid-operation:**
  - `rst` while in REQ → `mem_req`, `busy` = 0 immediately.
  - Then ack pulse → no `wr_en`.
  - Then a legal load completes normally.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared MIX definitions: word geometry, load opcode range, register indices,
// load-sequencer states and the partial-field legality check.
package mix_pkg;

  localparam int WORD_W      = 31;
  localparam int BYTE_W      = 6;
  localparam int ADDR_W      = 12;
  localparam int OP_LD_FIRST = 8;
  localparam int OP_LD_LAST  = 23;

  localparam logic [2:0] REG_A  = 3'd0;
  localparam logic [2:0] REG_I1 = 3'd1;
  localparam logic [2:0] REG_I2 = 3'd2;
  localparam logic [2:0] REG_I3 = 3'd3;
  localparam logic [2:0] REG_I4 = 3'd4;
  localparam logic [2:0] REG_I5 = 3'd5;
  localparam logic [2:0] REG_I6 = 3'd6;
  localparam logic [2:0] REG_X  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } ld_state_e;

  // F = 8L+R is usable only when L <= R <= 5.
  function automatic logic field_ok(input logic [5:0] f);
    return (f[5:3] <= f[2:0]) && (f[2:0] <= 3'd5);
  endfunction

endpackage

// File: rtl/field_sel.sv
// Combinational MIX partial-field extractor: bytes max(L,1)..R right-justified,
// sign kept only when the field starts at 0.
module field_sel
  import mix_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [5:0]        field_i,
  output logic [WORD_W-1:0] word_o,
  output logic              valid_o
);

  logic [2:0]  l;
  logic [2:0]  r;
  logic [2:0]  lo;
  logic [29:0] shifted;
  logic [29:0] mag;
  logic        sign;

  always_comb begin
    l       = field_i[5:3];
    r       = field_i[2:0];
    lo      = (l == 3'd0) ? 3'd1 : l;
    valid_o = field_ok(field_i);
    shifted = '0;
    mag     = '0;
    if (valid_o) begin
      shifted = word_i[29:0] >> (BYTE_W * (5 - int'(r)));
      // (0:0) gives R - lo + 1 = 0 bytes, i.e. sign only.
      for (int j = 0; j < 5; j++) begin
        if (j < int'(r) - int'(lo) + 1) begin
          mag[j*BYTE_W +: BYTE_W] = shifted[j*BYTE_W +: BYTE_W];
        end
      end
    end
    sign   = (l == 3'd0) ? word_i[30] : 1'b0;
    word_o = {sign, mag};
  end

endmodule

// File: rtl/ld_seq.sv
// MIX load sequencer (LDA..LDXN): validate, fetch operand over req/ack,
// extract field, apply negation and index truncation, issue one register write.
module ld_seq
  import mix_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [5:0]        field,
  input  logic [ADDR_W-1:0] addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_data,
  output logic              wr_en,
  output logic [2:0]        wr_sel,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  ld_state_e         state_q, state_d;
  logic              neg_q, neg_d;
  logic [2:0]        tgt_q, tgt_d;
  logic [5:0]        field_q, field_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [2:0]        wr_sel_q, wr_sel_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;

  logic [WORD_W-1:0] ext;
  logic              ext_valid;
  logic [WORD_W-1:0] wb_word;
  logic              sgn;
  logic              start_legal;

  field_sel u_field_sel (
    .word_i  (mem_data),
    .field_i (field_q),
    .word_o  (ext),
    .valid_o (ext_valid)
  );

  always_comb begin
    sgn = ext[30] ^ neg_q;
    if (tgt_q != REG_A && tgt_q != REG_X) begin
      wb_word = {sgn, 18'd0, ext[11:0]};
    end else begin
      wb_word = {sgn, ext[29:0]};
    end
  end

  assign start_legal = (opcode >= 6'(OP_LD_FIRST)) && (opcode <= 6'(OP_LD_LAST))
                       && field_ok(field);

  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    tgt_d     = tgt_q;
    field_d   = field_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_sel_d  = wr_sel_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_d   = opcode[4];
          tgt_d   = opcode[2:0];
          field_d = field;
          addr_d  = addr;
          cnt_d   = '0;
          state_d = start_legal ? S_REQ : S_ERR;
        end
      end
      S_REQ: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (mem_ack) begin
          if (ext_valid) begin
            wr_sel_d  = tgt_q;
            wr_data_d = wb_word;
            state_d   = S_WB;
          end else begin
            state_d = S_ERR;
          end
        end else if (cnt_q == 10'(TIMEOUT)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      neg_q     <= 1'b0;
      tgt_q     <= '0;
      field_q   <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      neg_q     <= neg_d;
      tgt_q     <= tgt_d;
      field_q   <= field_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = addr_q;
  assign wr_en    = (state_q == S_WB);
  assign wr_sel   = wr_sel_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_WB) || (state_q == S_ERR);
  assign err      = (state_q == S_ERR);

endmodule
